multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32IM control FSM. Walks BOOT -> IF -> ID -> EX -> (MEM) -> (WB)
// and back to IF, or parks in TRAP on an illegal encoding or an MU timeout.
// The instruction class and the ALU/MU/result-mux selects are captured at the
// end of ID. Every datapath control is decoded from that captured state. The
// only exceptions are the branch PC select and the store PC write, which
// follow br_taken and dmem_ready in the same cycle.
module multicycle_controller #(
  parameter int pcmux_N     = 3,
  parameter int ifuresctl_N = 2,
  parameter int EX_TIMEOUT  = 64
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     func3,
  input  logic [1:0]                     func7b50,
  input  logic                           imem_ready,
  input  logic                           dmem_ready,
  input  logic                           ex_done,
  input  logic                           br_taken,
  output logic [$clog2(pcmux_N)-1:0]     pcmuxctl,
  output logic                           pcnextctl,
  output logic                           instrre,
  output logic                           regre,
  output logic                           regwe,
  output logic                           dmemre,
  output logic                           dmemwe,
  output logic [3:0]                     aluctl,
  output logic [1:0]                     mulctl,
  output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
  output logic                           ex_start,
  output logic                           illegal,
  output logic [2:0]                     state_o
);

  localparam int PCW = $clog2(pcmux_N);
  localparam int IFW = $clog2(ifuresctl_N);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_BOOT = 3'b101,
    S_TRAP = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } op_class_t;

  state_t           state;
  op_class_t        cls_q;
  logic [3:0]       alu_q;
  logic [1:0]       mul_q;
  logic [IFW-1:0]   ifu_q;
  logic             is_m_q;
  logic [6:0]       ex_cnt;

  op_class_t        dec_cls;
  logic [3:0]       dec_alu;
  logic [1:0]       dec_mul;
  logic [IFW-1:0]   dec_ifu;
  logic             dec_m;
  logic             dec_illegal;
  state_t           ex_next;

  // Instruction decode from the raw fields; only sampled at the end of ID.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    dec_cls     = C_ALU;
    dec_alu     = ALU_ADD;
    dec_mul     = '0;
    dec_ifu     = '0;
    dec_m       = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        dec_alu = {func7b50[1], func3};
        if (func7b50 == 2'b11) begin
          dec_illegal = 1'b1;
        end else if (func7b50[0]) begin
          // M extension: there is no divider, so divide/remainder traps.
          dec_m       = 1'b1;
          dec_mul     = func3[1:0];
          dec_ifu     = IFW'(1);
          dec_illegal = func3[2];
        end
      end
      OP_I:      dec_alu = {(func3 == 3'b101) & func7b50[1], func3};
      OP_LOAD:   dec_cls = C_LOAD;
      OP_STORE:  dec_cls = C_STORE;
      OP_BRANCH: begin
        dec_cls = C_BRANCH;
        dec_alu = ALU_SUB;
      end
      OP_JAL:    dec_cls = C_JAL;
      OP_JALR:   dec_cls = C_JALR;
      OP_LUI:    dec_alu = ALU_PASSB;
      OP_AUIPC:  dec_alu = ALU_ADD;
      default:   dec_illegal = 1'b1;
    endcase
  end

  // Successor of EX once the operation has finished.
  always_comb begin
    case (cls_q)
      C_LOAD, C_STORE: ex_next = S_MEM;
      C_BRANCH:        ex_next = S_IF;
      default:         ex_next = S_WB;
    endcase
  end

  // State sequencing, decode capture and the MU wait counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state  <= S_BOOT;
      cls_q  <= C_ALU;
      alu_q  <= '0;
      mul_q  <= '0;
      ifu_q  <= '0;
      is_m_q <= 1'b0;
      ex_cnt <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_IF;
        S_IF:   if (imem_ready) state <= S_ID;
        S_ID: begin
          cls_q  <= dec_cls;
          alu_q  <= dec_alu;
          mul_q  <= dec_mul;
          ifu_q  <= dec_ifu;
          is_m_q <= dec_m;
          ex_cnt <= '0;
          state  <= dec_illegal ? S_TRAP : S_EX;
        end
        S_EX: begin
          ex_cnt <= ex_cnt + 7'd1;
          if (!is_m_q || ex_done)                   state <= ex_next;
          else if (ex_cnt == 7'(EX_TIMEOUT - 1))    state <= S_TRAP;
        end
        S_MEM:  if (dmem_ready) state <= (cls_q == C_LOAD) ? S_WB : S_IF;
        S_WB:   state <= S_IF;
        S_TRAP: state <= S_TRAP;
        default: state <= S_BOOT;
      endcase
    end
  end

  // Datapath controls decoded from the current state and captured decode.
  always_comb begin
    pcmuxctl  = '0;
    pcnextctl = 1'b0;
    instrre   = 1'b0;
    regre     = 1'b0;
    regwe     = 1'b0;
    dmemre    = 1'b0;
    dmemwe    = 1'b0;
    aluctl    = '0;
    mulctl    = '0;
    ifuresctl = '0;
    ex_start  = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IF: instrre = 1'b1;
      S_ID: regre   = 1'b1;
      S_EX: begin
        aluctl    = alu_q;
        mulctl    = mul_q;
        ifuresctl = ifu_q;
        ex_start  = is_m_q && (ex_cnt == '0);
        if (cls_q == C_BRANCH) begin
          pcnextctl = 1'b1;
          pcmuxctl  = br_taken ? PCW'(1) : '0;
        end
      end
      S_MEM: begin
        aluctl    = alu_q;
        mulctl    = mul_q;
        ifuresctl = ifu_q;
        dmemre    = (cls_q == C_LOAD);
        dmemwe    = (cls_q == C_STORE);
        pcnextctl = (cls_q == C_STORE) && dmem_ready;
      end
      S_WB: begin
        aluctl    = alu_q;
        mulctl    = mul_q;
        ifuresctl = ifu_q;
        regwe     = 1'b1;
        pcnextctl = 1'b1;
        case (cls_q)
          C_JAL:   pcmuxctl = PCW'(1);
          C_JALR:  pcmuxctl = PCW'(2);
          default: pcmuxctl = '0;
        endcase
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. Each instruction is expanded by a reference
// model into an expected per-cycle trace, which lists the inputs to drive and
// the state and controls to expect. The trace is then replayed against the DUT.
// Inputs that must be ignored in a given state are randomised.
module tb_multicycle_controller;

  localparam int TO = 8;

  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EX = 3'b010,
                         ST_MEM = 3'b011, ST_WB = 3'b100, ST_BOOT = 3'b101,
                         ST_TRAP = 3'b111;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_JALR = 5;

  logic       clk = 1'b0;
  logic       rstn;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [1:0] func7b50;
  logic       imem_ready, dmem_ready, ex_done, br_taken;
  logic [1:0] pcmuxctl;
  logic       pcnextctl, instrre, regre, regwe, dmemre, dmemwe;
  logic [3:0] aluctl;
  logic [1:0] mulctl;
  logic [0:0] ifuresctl;
  logic       ex_start, illegal;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.pcmux_N(3), .ifuresctl_N(2), .EX_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .func3(func3), .func7b50(func7b50),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .ex_done(ex_done),
    .br_taken(br_taken), .pcmuxctl(pcmuxctl), .pcnextctl(pcnextctl),
    .instrre(instrre), .regre(regre), .regwe(regwe), .dmemre(dmemre),
    .dmemwe(dmemwe), .aluctl(aluctl), .mulctl(mulctl), .ifuresctl(ifuresctl),
    .ex_start(ex_start), .illegal(illegal), .state_o(state_o)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [1:0] f7;
  } ins_t;

  typedef struct {
    ins_t        ins;
    logic        imem, dmem, exd, br;
    logic [2:0]  st;
    logic [16:0] out;
  } cyc_t;

  cyc_t tr[$];

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected control bundle, in a fixed field order.
  function automatic logic [16:0] pack(logic ir, logic rr, logic rw, logic pcn,
                                       logic [1:0] pcm, logic dre, logic dwe,
                                       logic [3:0] alu, logic [1:0] mul, logic ifu,
                                       logic exs, logic ill);
    return {ir, rr, rw, pcn, pcm, dre, dwe, alu, mul, ifu, exs, ill};
  endfunction

  function automatic void push(ins_t i, logic [2:0] st, logic imem, logic dmem,
                               logic exd, logic br, logic [16:0] out);
    cyc_t c;
    c.ins = i; c.st = st; c.imem = imem; c.dmem = dmem; c.exd = exd; c.br = br;
    c.out = out;
    tr.push_back(c);
  endfunction

  // Architectural meaning of an encoding: legality, class and control selects.
  function automatic void ref_decode(input ins_t i, output bit legal, output int kind,
                                     output logic [3:0] alu, output logic [1:0] mul,
                                     output logic ifu, output bit m);
    legal = 1'b1; kind = K_ALU; alu = 4'b0000; mul = 2'b00; ifu = 1'b0; m = 1'b0;
    if (i.op == 7'b0110011) begin
      alu = {i.f7[1], i.f3};
      if (i.f7 == 2'b11) legal = 1'b0;
      if (i.f7 == 2'b01) begin
        m = 1'b1; mul = i.f3[1:0]; ifu = 1'b1;
        if (i.f3 >= 3'd4) legal = 1'b0;
      end
    end else if (i.op == 7'b0010011) alu = {(i.f3 == 3'd5) && i.f7[1], i.f3};
    else if (i.op == 7'b0000011) kind = K_LOAD;
    else if (i.op == 7'b0100011) kind = K_STORE;
    else if (i.op == 7'b1100011) begin kind = K_BR; alu = 4'b1000; end
    else if (i.op == 7'b1101111) kind = K_JAL;
    else if (i.op == 7'b1100111) kind = K_JALR;
    else if (i.op == 7'b0110111) alu = 4'b1111;
    else if (i.op == 7'b0010111) alu = 4'b0000;
    else legal = 1'b0;
  endfunction

  // Expand one instruction into its expected cycle trace. ex_lat < 0 means
  // ex_done never arrives.
  function automatic void build(ins_t i, int imem_d, int ex_lat, int dmem_d, logic br_t);
    bit legal, m;
    int kind;
    logic [3:0] alu;
    logic [1:0] mul;
    logic ifu;
    int n_ex;
    ref_decode(i, legal, kind, alu, mul, ifu, m);
    for (int k = 0; k < imem_d; k++)
      push(i, ST_IF, 1'b0, rb(), rb(), rb(), pack(1,0,0,0,2'd0,0,0,4'd0,2'd0,0,0,0));
    push(i, ST_IF, 1'b1, rb(), rb(), rb(), pack(1,0,0,0,2'd0,0,0,4'd0,2'd0,0,0,0));
    push(i, ST_ID, rb(), rb(), rb(), rb(), pack(0,1,0,0,2'd0,0,0,4'd0,2'd0,0,0,0));
    if (!legal) begin
      for (int k = 0; k < 3; k++)
        push(i, ST_TRAP, rb(), rb(), rb(), rb(), pack(0,0,0,0,2'd0,0,0,4'd0,2'd0,0,0,1));
      return;
    end
    if (m) begin
      n_ex = (ex_lat < 0) ? TO : ex_lat + 1;
      for (int c = 0; c < n_ex; c++)
        push(i, ST_EX, rb(), rb(), (ex_lat >= 0) && (c == ex_lat), rb(),
             pack(0,0,0,0,2'd0,0,0,alu,mul,ifu,c == 0,0));
      if (ex_lat < 0) begin
        for (int k = 0; k < 3; k++)
          push(i, ST_TRAP, rb(), rb(), rb(), rb(), pack(0,0,0,0,2'd0,0,0,4'd0,2'd0,0,0,1));
        return;
      end
    end else if (kind == K_BR) begin
      push(i, ST_EX, rb(), rb(), rb(), br_t,
           pack(0,0,0,1,br_t ? 2'd1 : 2'd0,0,0,alu,mul,ifu,0,0));
      return;
    end else begin
      push(i, ST_EX, rb(), rb(), rb(), rb(), pack(0,0,0,0,2'd0,0,0,alu,mul,ifu,0,0));
    end
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int k = 0; k < dmem_d; k++)
        push(i, ST_MEM, rb(), 1'b0, rb(), rb(),
             pack(0,0,0,0,2'd0,kind == K_LOAD,kind == K_STORE,alu,mul,ifu,0,0));
      push(i, ST_MEM, rb(), 1'b1, rb(), rb(),
           pack(0,0,0,kind == K_STORE,2'd0,kind == K_LOAD,kind == K_STORE,alu,mul,ifu,0,0));
      if (kind == K_STORE) return;
    end
    push(i, ST_WB, rb(), rb(), rb(), rb(),
         pack(0,0,1,1,(kind == K_JAL) ? 2'd1 : (kind == K_JALR) ? 2'd2 : 2'd0,
              0,0,alu,mul,ifu,0,0));
  endfunction

  // Fetch stalled: IF held with imem_ready low.
  function automatic void push_idle(ins_t i, int n);
    for (int k = 0; k < n; k++)
      push(i, ST_IF, 1'b0, rb(), rb(), rb(), pack(1,0,0,0,2'd0,0,0,4'd0,2'd0,0,0,0));
  endfunction

  function automatic ins_t mk(logic [6:0] op, logic [2:0] f3, logic [1:0] f7);
    ins_t i;
    i.op = op; i.f3 = f3; i.f7 = f7;
    return i;
  endfunction

  function automatic logic [16:0] observed();
    return {instrre, regre, regwe, pcnextctl, pcmuxctl, dmemre, dmemwe,
            aluctl, mulctl, ifuresctl, ex_start, illegal};
  endfunction

  // Replay the queued trace (at most limit cycles); entered and left on a negedge.
  task automatic play(input string tag, input int limit);
    cyc_t c;
    int n = 0;
    while (tr.size() > 0) begin
      c = tr.pop_front();
      if (n < limit) begin
        opcode = c.ins.op; func3 = c.ins.f3; func7b50 = c.ins.f7;
        imem_ready = c.imem; dmem_ready = c.dmem; ex_done = c.exd; br_taken = c.br;
        #1;
        n_cmp++;
        if (state_o !== c.st) begin
          n_bad++;
          $display("FAIL %s cyc %0d state_o got %b want %b", tag, n, state_o, c.st);
        end
        n_cmp++;
        if (observed() !== c.out) begin
          n_bad++;
          $display("FAIL %s cyc %0d controls got %b want %b (state %b)",
                   tag, n, observed(), c.out, c.st);
        end
        @(negedge clk);
      end
      n++;
    end
  endtask

  // Asynchronous reset mid-cycle, then one BOOT cycle after release.
  task automatic do_reset();
    #2;
    imem_ready = 1'b1; dmem_ready = 1'b1; ex_done = 1'b1; br_taken = 1'b1;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== ST_BOOT || observed() !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_async state got %b want %b controls got %b want 0",
               state_o, ST_BOOT, observed());
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (state_o !== ST_BOOT || observed() !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_boot state got %b want %b controls got %b want 0",
               state_o, ST_BOOT, observed());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    build(mk(7'b0110011, 3'b000, 2'b00), 0, 0, 0, 1'b0);
    push_idle(mk(7'b0110011, 3'b000, 2'b00), 1);
    play("add", 1000);
  endtask

  task automatic test_alu();
    do_reset();
    build(mk(7'b0110011, 3'b000, 2'b10), 0, 0, 0, 1'b0);
    build(mk(7'b0010011, 3'b101, 2'b10), 3, 0, 0, 1'b0);
    build(mk(7'b0110111, 3'b010, 2'b11), 1, 0, 0, 1'b0);
    build(mk(7'b0010111, 3'b111, 2'b00), 0, 0, 0, 1'b0);
    play("sub_srai_lui_auipc", 1000);
  endtask

  task automatic test_mul();
    do_reset();
    build(mk(7'b0110011, 3'b011, 2'b01), 0, 5, 0, 1'b0);
    build(mk(7'b0110011, 3'b000, 2'b01), 0, 0, 0, 1'b0);
    build(mk(7'b0110011, 3'b001, 2'b01), 2, TO - 1, 0, 1'b0);
    play("mul", 1000);
  endtask

  task automatic test_timeout();
    do_reset();
    build(mk(7'b0110011, 3'b010, 2'b01), 0, -1, 0, 1'b0);
    play("mul_timeout", 1000);
    do_reset();
    build(mk(7'b0110011, 3'b100, 2'b00), 0, 0, 0, 1'b0);
    play("after_trap", 1000);
  endtask

  task automatic test_mem();
    do_reset();
    build(mk(7'b0000011, 3'b010, 2'b00), 0, 0, 2, 1'b0);
    build(mk(7'b0100011, 3'b010, 2'b00), 0, 0, 1, 1'b0);
    build(mk(7'b0110011, 3'b111, 2'b00), 0, 0, 0, 1'b0);
    play("load_store", 1000);
  endtask

  task automatic test_back_to_back();
    do_reset();
    build(mk(7'b1100011, 3'b000, 2'b00), 0, 0, 0, 1'b1);
    build(mk(7'b1100011, 3'b001, 2'b00), 0, 0, 0, 1'b0);
    build(mk(7'b1101111, 3'b000, 2'b00), 0, 0, 0, 1'b0);
    build(mk(7'b1100111, 3'b000, 2'b00), 0, 0, 0, 1'b0);
    build(mk(7'b1111111, 3'b000, 2'b00), 0, 0, 0, 1'b0);
    play("branch_jump_illegal", 1000);
    do_reset();
    build(mk(7'b0110011, 3'b101, 2'b01), 0, 0, 0, 1'b0);
    play("div_illegal", 1000);
    do_reset();
    build(mk(7'b0110011, 3'b000, 2'b11), 0, 0, 0, 1'b0);
    play("f7_11_illegal", 1000);
  endtask

  task automatic test_mid_reset();
    do_reset();
    build(mk(7'b0110011, 3'b000, 2'b01), 0, -1, 0, 1'b0);
    play("mid_ex", 5);
    do_reset();
    push_idle(mk(7'b0110011, 3'b000, 2'b01), 4);
    play("after_mid_reset", 1000);
  endtask

  task automatic test_random();
    logic [6:0] ops [9];
    ins_t i;
    bit legal, m;
    int kind;
    logic [3:0] alu;
    logic [1:0] mul;
    logic ifu;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    do_reset();
    for (int n = 0; n < 60; n++) begin
      i.op = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      i.f3 = 3'($urandom);
      i.f7 = 2'($urandom);
      ref_decode(i, legal, kind, alu, mul, ifu, m);
      build(i, $urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom_range(0, 3), rb());
      play("random", 1000);
      if (!legal) do_reset();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    opcode = '0; func3 = '0; func7b50 = '0;
    imem_ready = 1'b0; dmem_ready = 1'b0; ex_done = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_mul();
    test_timeout();
    test_mem();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
